// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline front registers: the NOP encoding, the reset PC,
// and the layout of the decoded control bundle.
package pipe_pkg;

  localparam int          CTRL_W    = 12;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Control-bundle bit positions
  localparam int CTRL_RESULTSRC0 = 0;
  localparam int CTRL_REGWRITE   = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALUSRC     = 5;
  localparam int CTRL_ALUCTL_LO  = 6;
  localparam int CTRL_ALUCTL_HI  = 8;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with async reset, synchronous clear (wins over enable) and load enable.
// Clear loads the same value as reset, so a flushed stage looks exactly like a reset one.
module pipe_reg_en_clr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= RESET_VAL;
    else if (clr) q <= RESET_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the RV32I pipeline, driven by the hazard unit's stall/flush.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_front_regs #(
  parameter int          XLEN     = 32,
  parameter int          CTRL_W   = pipe_pkg::CTRL_W,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  output logic [XLEN-1:0]   PCF,
  input  logic [31:0]       InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ResultSrcE0,
  output logic              ValidE,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);
  import pipe_pkg::*;

  localparam int IFID_W = 32 + 2*XLEN + 1;
  localparam int IDEX_W = CTRL_W + 5*XLEN + 15 + 1;
  localparam logic [XLEN-1:0]   PC_RST   = RESET_PC[XLEN-1:0];
  localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {(2*XLEN+1){1'b0}}};

  logic [IFID_W-1:0] ifidQ;
  logic [IDEX_W-1:0] idexQ;

  pipe_reg_en_clr #(.WIDTH(XLEN), .RESET_VAL(PC_RST)) uPc (
    .clk(clk), .reset(reset), .en(!StallF), .clr(1'b0), .d(PCNextF), .q(PCF)
  );

  // A bubble in IF/ID carries NOP so downstream decode sees a harmless instruction
  pipe_reg_en_clr #(.WIDTH(IFID_W), .RESET_VAL(IFID_RST)) uIfId (
    .clk(clk), .reset(reset), .en(!StallD), .clr(FlushD),
    .d({InstrF, PCF, PCPlus4F, 1'b1}), .q(ifidQ)
  );
  assign {InstrD, PCD, PCPlus4D, ValidD} = ifidQ;

  pipe_reg_en_clr #(.WIDTH(IDEX_W), .RESET_VAL('0)) uIdEx (
    .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE),
    .d({CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD}), .q(idexQ)
  );
  assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = idexQ;
  assign ResultSrcE0 = CtrlE[CTRL_RESULTSRC0];

`ifdef PIPE_PERF_CNT_EN
  // Flushes coinciding with a stall are load-use bubbles, already counted as stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD)            StallCnt <= StallCnt + 32'd1;
      if (FlushE && !StallD) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed table-driven bench for pipe_front_regs plus hand sequences for reset and reset-mid-stall.
module tb_pipe_front_regs;

  logic        clk = 1'b0, reset;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, PCF, InstrF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic        ValidD, ValidE, ResultSrcE0;
  logic [31:0] RD1D, RD2D, ImmExtD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic [11:0] CtrlD, CtrlE;
  logic [31:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_front_regs dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .PCF(PCF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .CtrlD(CtrlD),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE), .ResultSrcE0(ResultSrcE0), .ValidE(ValidE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct {
    logic        sF, sD, fD, fE;
    logic [31:0] pcNext, instr;
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] ePC, eInstrD, ePcD;
    logic        eVD;
    logic [11:0] eCtrlE;
    logic        eVE;
    logic [4:0]  eRdE;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " PCF"}, PCF, 32'h0);
    chk({tag, " InstrD"}, InstrD, 32'h0000_0013);
    chk({tag, " ValidD"}, {31'd0, ValidD}, 32'd0);
    chk({tag, " ValidE"}, {31'd0, ValidE}, 32'd0);
    chk({tag, " CtrlE"}, {20'd0, CtrlE}, 32'd0);
    chk({tag, " RdE"}, {27'd0, RdE}, 32'd0);
    chk({tag, " StallCnt"}, StallCnt, 32'd0);
    chk({tag, " FlushCnt"}, FlushCnt, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] curPC, prevPcD, expStall, expFlush;

    //          sF sD fD fE pcNext        instrF        ctrl    rd  ePC           eInstrD       ePcD          eVD eCtrlE  eVE eRdE
    vecs[0]  = '{0, 0, 0, 0, 32'h04,       32'h00100113, 12'h000, 0, 32'h04,       32'h00100113, 32'h00,       1, 12'h000, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h08,       32'h00200193, 12'h002, 2, 32'h08,       32'h00200193, 32'h04,       1, 12'h002, 1, 2};
    vecs[2]  = '{0, 0, 0, 0, 32'h0C,       32'h00500093, 12'h002, 3, 32'h0C,       32'h00500093, 32'h08,       1, 12'h002, 1, 3};
    vecs[3]  = '{0, 0, 0, 0, 32'h10,       32'h0000a203, 12'h002, 1, 32'h10,       32'h0000a203, 32'h0C,       1, 12'h002, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 32'h14,       32'h004202b3, 12'h003, 4, 32'h14,       32'h004202b3, 32'h10,       1, 12'h003, 1, 4};
    // load-use: lw in E, dependent add held in D, one bubble into E
    vecs[5]  = '{1, 1, 0, 1, 32'h18,       32'h00628333, 12'h002, 5, 32'h14,       32'h004202b3, 32'h10,       1, 12'h000, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h18,       32'h00628333, 12'h002, 5, 32'h18,       32'h00628333, 32'h14,       1, 12'h002, 1, 5};
    // taken branch to 0x40
    vecs[7]  = '{0, 0, 1, 1, 32'h40,       32'h00700393, 12'h008, 6, 32'h40,       32'h00000013, 32'h00,       0, 12'h000, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 32'h44,       32'h00800413, 12'h000, 0, 32'h44,       32'h00800413, 32'h40,       1, 12'h000, 0, 0};
    // FlushD with StallD (and StallF): flush wins in IF/ID, PC holds
    vecs[9]  = '{1, 1, 1, 0, 32'h48,       32'h00900493, 12'h002, 8, 32'h44,       32'h00000013, 32'h00,       0, 12'h002, 1, 8};
    vecs[10] = '{0, 0, 0, 0, 32'h48,       32'h00900493, 12'h000, 0, 32'h48,       32'h00900493, 32'h44,       1, 12'h000, 0, 0};

    reset = 1'b1;
    {StallF, StallD, FlushD, FlushE} = '0;
    PCNextF = 32'h4; PCPlus4F = 32'h4; InstrF = 32'h00100113;
    CtrlD = '0; RdD = '0; Rs1D = '0; Rs2D = '0; RD1D = '0; RD2D = '0; ImmExtD = '0;
    repeat (3) @(posedge clk);
    #1;
    chkReset("reset");
    reset = 1'b0;

    curPC = 32'h0; prevPcD = 32'h0; expStall = 0; expFlush = 0;
    for (int i = 0; i < 11; i++) begin
      {StallF, StallD, FlushD, FlushE} = {vecs[i].sF, vecs[i].sD, vecs[i].fD, vecs[i].fE};
      PCNextF  = vecs[i].pcNext;
      PCPlus4F = curPC + 32'd4;
      InstrF   = vecs[i].instr;
      CtrlD    = vecs[i].ctrl;
      RdD      = vecs[i].rd;
      Rs1D     = vecs[i].rd ^ 5'h01;
      Rs2D     = vecs[i].rd ^ 5'h02;
      RD1D     = 32'hA000_0000 | {27'd0, vecs[i].rd};
      RD2D     = 32'hB000_0000 | {27'd0, vecs[i].rd};
      ImmExtD  = 32'h0000_0100 | {27'd0, vecs[i].rd};
      if (vecs[i].sD) expStall++;
      if (vecs[i].fE && !vecs[i].sD) expFlush++;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d PCF", i), PCF, vecs[i].ePC);
      chk($sformatf("v%0d InstrD", i), InstrD, vecs[i].eInstrD);
      chk($sformatf("v%0d PCD", i), PCD, vecs[i].ePcD);
      chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, vecs[i].eVD ? vecs[i].ePcD + 32'd4 : 32'd0);
      chk($sformatf("v%0d ValidD", i), {31'd0, ValidD}, {31'd0, vecs[i].eVD});
      chk($sformatf("v%0d CtrlE", i), {20'd0, CtrlE}, {20'd0, vecs[i].eCtrlE});
      chk($sformatf("v%0d ResultSrcE0", i), {31'd0, ResultSrcE0}, {31'd0, vecs[i].eCtrlE[0]});
      chk($sformatf("v%0d ValidE", i), {31'd0, ValidE}, {31'd0, vecs[i].eVE});
      chk($sformatf("v%0d RdE", i), {27'd0, RdE}, {27'd0, vecs[i].eRdE});
      chk($sformatf("v%0d Rs1E", i), {27'd0, Rs1E}, vecs[i].fE ? 32'd0 : {27'd0, vecs[i].rd ^ 5'h01});
      chk($sformatf("v%0d Rs2E", i), {27'd0, Rs2E}, vecs[i].fE ? 32'd0 : {27'd0, vecs[i].rd ^ 5'h02});
      chk($sformatf("v%0d RD1E", i), RD1E, vecs[i].fE ? 32'd0 : (32'hA000_0000 | {27'd0, vecs[i].rd}));
      chk($sformatf("v%0d ImmExtE", i), ImmExtE, vecs[i].fE ? 32'd0 : (32'h0000_0100 | {27'd0, vecs[i].rd}));
      chk($sformatf("v%0d PCE", i), PCE, vecs[i].fE ? 32'd0 : prevPcD);
`ifdef PIPE_PERF_CNT_EN
      chk($sformatf("v%0d StallCnt", i), StallCnt, expStall);
      chk($sformatf("v%0d FlushCnt", i), FlushCnt, expFlush);
`else
      chk($sformatf("v%0d StallCnt", i), StallCnt, 32'd0);
      chk($sformatf("v%0d FlushCnt", i), FlushCnt, 32'd0);
`endif
      curPC   = vecs[i].ePC;
      prevPcD = vecs[i].ePcD;
    end

    // Reset asserted between edges while stalled: must take effect without a clock edge
    {StallF, StallD, FlushD, FlushE} = 4'b1100;
    @(posedge clk);
    #1;
`ifdef PIPE_PERF_CNT_EN
    chk("prestall StallCnt", StallCnt, expStall + 32'd1);
`else
    chk("prestall StallCnt", StallCnt, 32'd0);
`endif
    chk("prestall PCF", PCF, 32'h48);
    #2;
    reset = 1'b1;
    #1;
    chkReset("midstall reset");
    @(posedge clk);
    #1;
    {StallF, StallD, FlushD, FlushE} = '0;
    PCNextF = 32'h4; PCPlus4F = 32'h4; InstrF = 32'h00100113;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset PCF", PCF, 32'h4);
    chk("post-reset InstrD", InstrD, 32'h00100113);
    chk("post-reset ValidD", {31'd0, ValidD}, 32'd1);
    chk("post-reset StallCnt", StallCnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
